// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the default fetch address and the
// basic PC / instruction types used by the fetch stage and memory wrappers.
package cpu_pkg;

  localparam int PC_W   = 8;   // word address width (256-word instruction memory)
  localparam int INST_W = 32;  // instruction width

  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [INST_W-1:0] inst_t;

  localparam pc_t DEFAULT_RESET_PC = '0;

endpackage : cpu_pkg

// File: rtl/pc_next.sv
// Combinational next-PC logic: selects the instruction-memory address for
// this cycle and the value the PC register takes at the next edge.
// Priority is redirect > stall > sequential. Arithmetic wraps modulo 2^PC_W.
module pc_next
  import cpu_pkg::*;
(
  input  logic stall,
  input  logic redirect,
  input  pc_t  pc,           // next sequential address to fetch
  input  pc_t  req_pc,       // address whose word is currently on the memory output
  input  pc_t  redirect_pc,  // branch/jump target
  output pc_t  fetch_addr,   // address presented to inst_mem this cycle
  output pc_t  pc_d,         // PC value after the coming edge
  output logic advance       // the IF/ID register loads fetch_addr at the coming edge
);

  // Address select and increment; a stall re-reads req_pc so memory recaptures the same word.
  always_comb begin
    fetch_addr = pc;
    pc_d       = pc;
    advance    = 1'b0;
    if (redirect) begin
      fetch_addr = redirect_pc;
      pc_d       = redirect_pc + pc_t'(1);
      advance    = 1'b1;
    end else if (stall) begin
      fetch_addr = req_pc;
      pc_d       = pc;
      advance    = 1'b0;
    end else begin
      fetch_addr = pc;
      pc_d       = pc + pc_t'(1);
      advance    = 1'b1;
    end
  end

endmodule : pc_next

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the inst_mem address and
// presents the registered instruction to decode across the IF/ID boundary.
// A redirect fetches its target in the same cycle, so no bubble follows a squash.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter pc_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_pc,
  output logic              id_valid,
  output logic [31:0]       fetch_count
);

  pc_t         pc_q, pc_d;
  pc_t         req_pc_q, req_pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        advance;

  pc_next u_pc_next (
    .stall       (stall),
    .redirect    (redirect),
    .pc          (pc_q),
    .req_pc      (req_pc_q),
    .redirect_pc (redirect_pc),
    .fetch_addr  (imem_addr),
    .pc_d        (pc_d),
    .advance     (advance)
  );

  // Next-state for the IF/ID tag and the delivered-instruction counter.
  always_comb begin
    req_pc_d      = req_pc_q;
    req_valid_d   = req_valid_q;
    fetch_count_d = fetch_count_q;
    if (advance) begin
      req_pc_d    = imem_addr;
      req_valid_d = 1'b1;
    end
    // An instruction counts as handed over only when decode takes it and it is not squashed.
    if (req_valid_q && !stall && !redirect) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // State registers; reset drops any in-flight fetch immediately.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      req_valid_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      req_valid_q   <= req_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign id_inst     = imem_inst;
  assign id_pc       = req_pc_q;
  assign id_valid    = req_valid_q;
  assign fetch_count = fetch_count_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus updates a behavioural model of
// the fetch stream and queues the expected IF/ID contents; a monitor pops and
// compares after each clock edge. inst_mem is modelled with mem[k] = 0x100*k.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  pc_t         redirect_pc;
  pc_t         imem_addr;
  inst_t       imem_inst;
  inst_t       id_inst;
  pc_t         id_pc;
  logic        id_valid;
  logic [31:0] fetch_count;

  fetch_stage #(.RESET_PC(8'd0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_inst   (imem_inst),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_valid    (id_valid),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Registered instruction memory.
  inst_t mem [256];
  initial for (int k = 0; k < 256; k++) mem[k] = 32'(k) * 32'h100;
  always @(posedge clk) imem_inst <= mem[imem_addr];

  typedef struct {
    pc_t         pc;
    logic        valid;
    inst_t       inst;
    logic [31:0] count;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: what decode currently sees, and where sequential fetch continues.
  pc_t         m_shown;
  logic        m_valid;
  pc_t         m_next;
  logic [31:0] m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_shown = 8'd0;
    m_valid = 1'b0;
    m_next  = 8'd0;
    m_count = 32'd0;
  endtask

  // Called shortly after a rising edge: drive inputs for the next edge, check
  // the combinational address, advance the model and queue its expectation.
  task automatic step(input logic st, input logic rd, input pc_t tgt);
    exp_t e;
    pc_t  exp_addr;
    stall       = st;
    redirect    = rd;
    redirect_pc = tgt;
    #1;
    exp_addr = rd ? tgt : (st ? m_shown : m_next);
    check("imem_addr", 32'(imem_addr), 32'(exp_addr));
    if (rd) begin
      m_shown = tgt;
      m_valid = 1'b1;
      m_next  = pc_t'((int'(tgt) + 1) % 256);
    end else if (!st) begin
      if (m_valid) m_count = m_count + 32'd1;
      m_shown = m_next;
      m_valid = 1'b1;
      m_next  = pc_t'((int'(m_next) + 1) % 256);
    end
    e.pc    = m_shown;
    e.valid = m_valid;
    e.inst  = 32'(m_shown) * 32'h100;
    e.count = m_count;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expectation belongs to each edge; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        @(negedge clk);
        check("id_valid", 32'(id_valid), 32'(e.valid));
        check("id_pc", 32'(id_pc), 32'(e.pc));
        if (e.valid) check("id_inst", id_inst, e.inst);
        check("fetch_count", fetch_count, e.count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic st, rd;
    int   r;
    pc_t  tgt;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'd0;
    model_reset();
    #12;
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_pc", 32'(id_pc), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Free run, stall while id_pc=2, then redirects and wrap.
    repeat (3) step(1'b0, 1'b0, 8'd0);
    repeat (3) step(1'b1, 1'b0, 8'd0);
    repeat (3) step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 8'h40);
    step(1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 8'h10);
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 8'hFE);
    repeat (3) step(1'b0, 1'b0, 8'd0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      r   = int'($urandom_range(0, 99));
      rd  = (r < 10) || (r >= 95);
      st  = (r >= 10 && r < 35) || (r >= 95);
      tgt = ($urandom_range(0, 3) == 0) ? 8'hFF : pc_t'($urandom);
      step(st, rd, tgt);
    end

    // Async reset between edges, after the last expectation has been compared.
    stall = 1'b1;
    #6;
    rst_n = 1'b0;
    #1;
    check("async_rst_id_valid", 32'(id_valid), 32'd0);
    check("async_rst_fetch_count", fetch_count, 32'd0);
    check("async_rst_id_pc", 32'(id_pc), 32'd0);
    check("async_rst_imem_addr", 32'(imem_addr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (5) step(1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_stage
